// File: rtl/bi_set_register.sv
// BiSet configuration-bus slave: DEPTH words of WIDTH bits at ADDR..ADDR+DEPTH-1.
// Optional BISET_REG_ERR_EN: flag writes to read-only words with err=1.
module bi_set_register #(
  parameter int unsigned ADDR     = 1,
  parameter int unsigned DEPTH    = 1,
  parameter int unsigned WIDTH    = 32,
  parameter bit          WRITABLE = 1'b1,
  parameter logic [31:0] RESET    = 32'hdeadaffe
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [17:0]            setCtrl_i,
  input  logic [31:0]            setWrite_i,
  output logic [33:0]            setReply_o,
  output logic [DEPTH*WIDTH-1:0] val_o,
  output logic [DEPTH-1:0]       event_o
);

  logic                         w_valid, w_write, w_hit, w_wr_en, w_err;
  logic [15:0]                  w_addr;
  logic [31:0]                  w_off;
  logic [WIDTH-1:0]             w_cur;
  logic [31:0]                  w_data;
  logic [DEPTH-1:0]             w_we;

  logic [DEPTH-1:0][WIDTH-1:0]  r_words;
  logic [33:0]                  r_reply;
  logic [DEPTH-1:0]             r_event;

  assign w_valid = setCtrl_i[17];
  assign w_write = setCtrl_i[16];
  assign w_addr  = setCtrl_i[15:0];

  // Offset is computed in 32 bits so an address below ADDR can never alias into the window.
  assign w_off   = 32'(w_addr) - 32'(ADDR);
  assign w_hit   = w_valid && (32'(w_addr) >= 32'(ADDR)) && (w_off < 32'(DEPTH));
  assign w_wr_en = w_hit && w_write && WRITABLE;

`ifdef BISET_REG_ERR_EN
  assign w_err = w_hit && w_write && !WRITABLE;
`else
  assign w_err = 1'b0;
`endif

  always_comb begin
    w_cur = '0;
    w_we  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (w_off == 32'(i)) begin
        w_cur   = r_words[i];
        w_we[i] = w_wr_en;
      end
    end
  end

  // Reply carries the post-write value, so a write reply matches what val_o shows next cycle.
  always_comb begin
    w_data = '0;
    w_data[WIDTH-1:0] = w_wr_en ? setWrite_i[WIDTH-1:0] : w_cur;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_words[i] <= RESET[WIDTH-1:0];
      r_reply <= '0;
      r_event <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++)
        if (w_we[i]) r_words[i] <= setWrite_i[WIDTH-1:0];
      r_reply <= w_hit ? {1'b1, w_err, w_data} : 34'd0;
      r_event <= w_we;
    end
  end

  assign setReply_o = r_reply;
  assign val_o      = r_words;
  assign event_o    = r_event;

endmodule

// File: tb/tb_bi_set_register.sv
// Bench: constant, register, 4-word regfile and 8-bit register share one bus; replies OR-combined.
// Model is an address-indexed table of word values checked against replies, events and val_o.
module tb_bi_set_register;

`ifdef BISET_REG_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [17:0]  ctrl = '0;
  logic [31:0]  wdata = '0;
  logic [33:0]  rep_c, rep_r, rep_f, rep_b, reply;
  logic [31:0]  val_c, val_r;
  logic [127:0] val_f;
  logic [7:0]   val_b;
  logic [0:0]   ev_c, ev_r, ev_b;
  logic [3:0]   ev_f;
  logic [15:0]  act_ev;
  logic [199:0] all_val;

  always #5 clk = ~clk;

  bi_set_register #(.ADDR(1), .DEPTH(1), .WIDTH(32), .WRITABLE(1'b0), .RESET(32'hdeadaffe)) u_c (
    .clk_i(clk), .rst_i(rst_n), .setCtrl_i(ctrl), .setWrite_i(wdata),
    .setReply_o(rep_c), .val_o(val_c), .event_o(ev_c));
  bi_set_register #(.ADDR(2), .DEPTH(1), .WIDTH(32), .WRITABLE(1'b1), .RESET(32'haffebabe)) u_r (
    .clk_i(clk), .rst_i(rst_n), .setCtrl_i(ctrl), .setWrite_i(wdata),
    .setReply_o(rep_r), .val_o(val_r), .event_o(ev_r));
  bi_set_register #(.ADDR(3), .DEPTH(4), .WIDTH(32), .WRITABLE(1'b1), .RESET(32'habbadead)) u_f (
    .clk_i(clk), .rst_i(rst_n), .setCtrl_i(ctrl), .setWrite_i(wdata),
    .setReply_o(rep_f), .val_o(val_f), .event_o(ev_f));
  bi_set_register #(.ADDR(12), .DEPTH(1), .WIDTH(8), .WRITABLE(1'b1), .RESET(32'h000000c3)) u_b (
    .clk_i(clk), .rst_i(rst_n), .setCtrl_i(ctrl), .setWrite_i(wdata),
    .setReply_o(rep_b), .val_o(val_b), .event_o(ev_b));

  assign reply   = rep_c | rep_r | rep_f | rep_b;
  assign act_ev  = {3'b0, ev_b[0], 5'b0, ev_f, ev_r[0], ev_c[0], 1'b0};
  assign all_val = {val_b, val_f, val_r, val_c};

  // Behavioural model: one entry per bus address
  bit          m_here [16];
  bit          m_wr   [16];
  logic [31:0] m_mask [16];
  logic [31:0] m_rst  [16];
  logic [31:0] m_val  [16];
  logic [33:0] exp_reply;
  logic [15:0] exp_ev;
  int n_vec = 0, n_err = 0;

  function automatic void model_setup();
    for (int a = 0; a < 16; a++) begin
      m_here[a] = 0; m_wr[a] = 0; m_mask[a] = '0; m_rst[a] = '0;
    end
    m_here[1] = 1; m_wr[1] = 0; m_mask[1] = 32'hffffffff; m_rst[1] = 32'hdeadaffe;
    m_here[2] = 1; m_wr[2] = 1; m_mask[2] = 32'hffffffff; m_rst[2] = 32'haffebabe;
    for (int a = 3; a <= 6; a++) begin
      m_here[a] = 1; m_wr[a] = 1; m_mask[a] = 32'hffffffff; m_rst[a] = 32'habbadead;
    end
    m_here[12] = 1; m_wr[12] = 1; m_mask[12] = 32'h000000ff; m_rst[12] = 32'h000000c3;
  endfunction

  function automatic void model_reset();
    for (int a = 0; a < 16; a++) m_val[a] = m_rst[a] & m_mask[a];
    exp_reply = '0;
    exp_ev    = '0;
  endfunction

  function automatic logic [199:0] exp_vals();
    return {m_val[12][7:0], m_val[6], m_val[5], m_val[4], m_val[3], m_val[2], m_val[1]};
  endfunction

  // Drives one bus cycle, advances the model, and leaves outputs ready to sample.
  task automatic drive(input bit v, input bit w, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    ctrl  = {v, w, a};
    wdata = d;
    exp_reply = '0;
    exp_ev    = '0;
    if (v && a < 16 && m_here[a[3:0]]) begin
      if (w && m_wr[a[3:0]]) begin
        m_val[a[3:0]]  = d & m_mask[a[3:0]];
        exp_ev[a[3:0]] = 1'b1;
      end
      exp_reply = {1'b1, w && !m_wr[a[3:0]] && ERR_EN, m_val[a[3:0]]};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ctrl = '0; rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (reply !== 34'd0 || act_ev !== 16'd0) begin
      n_err++; $display("FAIL reset_outputs reply=%h ev=%h want 0/0", reply, act_ev);
    end
    n_vec++;
    if (all_val !== exp_vals()) begin
      n_err++; $display("FAIL reset_vals got=%h want=%h", all_val, exp_vals());
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_constant();
    drive(1, 0, 16'd1, 32'h0);
    n_vec++;
    if (reply !== {2'b10, 32'hdeadaffe}) begin
      n_err++; $display("FAIL const_read got=%h want=%h", reply, {2'b10, 32'hdeadaffe});
    end
    drive(1, 1, 16'd1, 32'h0);
    n_vec++;
    if (reply !== {1'b1, ERR_EN, 32'hdeadaffe} || act_ev !== 16'd0) begin
      n_err++; $display("FAIL const_write got=%h ev=%h want=%h ev=0", reply, act_ev, {1'b1, ERR_EN, 32'hdeadaffe});
    end
    drive(1, 0, 16'd1, 32'h0);
    n_vec++;
    if (reply !== exp_reply || val_c !== 32'hdeadaffe) begin
      n_err++; $display("FAIL const_reread got=%h val=%h want=%h", reply, val_c, exp_reply);
    end
  endtask

  task automatic test_register();
    drive(1, 0, 16'd2, 32'h0);
    n_vec++;
    if (reply !== {2'b10, 32'haffebabe}) begin
      n_err++; $display("FAIL reg_read got=%h want=%h", reply, {2'b10, 32'haffebabe});
    end
    drive(1, 1, 16'd2, 32'h12345678);
    n_vec++;
    if (reply !== {2'b10, 32'h12345678} || val_r !== 32'h12345678 || act_ev !== 16'h0004) begin
      n_err++; $display("FAIL reg_write reply=%h val=%h ev=%h want %h/12345678/0004", reply, val_r, act_ev, {2'b10, 32'h12345678});
    end
    drive(1, 0, 16'd2, 32'h0);
    n_vec++;
    if (reply !== exp_reply || act_ev !== 16'd0) begin
      n_err++; $display("FAIL reg_event_once reply=%h ev=%h want=%h ev=0", reply, act_ev, exp_reply);
    end
  endtask

  task automatic test_regfile();
    logic [15:0] addrs [5];
    addrs = '{16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    drive(1, 1, 16'd5, 32'h11);
    n_vec++;
    if (ev_f !== 4'b0100 || reply !== exp_reply) begin
      n_err++; $display("FAIL rf_write ev_f=%b reply=%h want 0100/%h", ev_f, reply, exp_reply);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, addrs[i], 32'h0);
      n_vec++;
      if (reply !== exp_reply || all_val !== exp_vals()) begin
        n_err++; $display("FAIL rf_read a=%0d got=%h want=%h", addrs[i], reply, exp_reply);
      end
    end
  endtask

  task automatic test_nohit();
    logic [15:0] addrs [4];
    addrs = '{16'd9, 16'd0, 16'd7, 16'hffff};
    for (int i = 0; i < 4; i++) begin
      drive(1, i[0], addrs[i], 32'hcafef00d);
      n_vec++;
      if (reply !== 34'd0 || act_ev !== 16'd0 || all_val !== exp_vals()) begin
        n_err++; $display("FAIL nohit a=%h reply=%h ev=%h want 0", addrs[i], reply, act_ev);
      end
    end
    drive(0, 1, 16'd2, 32'h77777777);
    n_vec++;
    if (reply !== 34'd0 || act_ev !== 16'd0 || val_r !== m_val[2]) begin
      n_err++; $display("FAIL invalid reply=%h ev=%h val_r=%h want 0/0/%h", reply, act_ev, val_r, m_val[2]);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 16'd2, 32'h0);
    n_vec++;
    if (reply !== exp_reply) begin
      n_err++; $display("FAIL b2b_first got=%h want=%h", reply, exp_reply);
    end
    drive(1, 0, 16'd3, 32'h0);
    n_vec++;
    if (reply !== exp_reply) begin
      n_err++; $display("FAIL b2b_second got=%h want=%h", reply, exp_reply);
    end
    drive(1, 1, 16'd4, 32'h0badf00d);
    drive(1, 0, 16'd4, 32'h0);
    n_vec++;
    if (reply !== {2'b10, 32'h0badf00d}) begin
      n_err++; $display("FAIL raw got=%h want=%h", reply, {2'b10, 32'h0badf00d});
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 16'd2, 32'h55);
    n_vec++;
    if (reply !== {2'b10, 32'h55} || act_ev !== 16'h0004) begin
      n_err++; $display("FAIL prereset_write reply=%h ev=%h", reply, act_ev);
    end
    #2;
    rst_n = 1'b0;
    ctrl  = '0;
    model_reset();
    #1;
    n_vec++;
    if (reply !== 34'd0 || act_ev !== 16'd0 || all_val !== exp_vals()) begin
      n_err++; $display("FAIL async_reset reply=%h ev=%h val_r=%h want 0/0/affebabe", reply, act_ev, val_r);
    end
    @(negedge clk) rst_n = 1'b1;
    drive(1, 0, 16'd2, 32'h0);
    n_vec++;
    if (reply !== {2'b10, 32'haffebabe}) begin
      n_err++; $display("FAIL post_reset_read got=%h want=%h", reply, {2'b10, 32'haffebabe});
    end
  endtask

  task automatic test_width8();
    drive(1, 1, 16'd12, 32'hfffffff0);
    n_vec++;
    if (val_b !== 8'hf0 || reply !== {2'b10, 32'h000000f0}) begin
      n_err++; $display("FAIL w8_write val=%h reply=%h want f0/%h", val_b, reply, {2'b10, 32'h000000f0});
    end
    drive(1, 0, 16'd12, 32'h0);
    n_vec++;
    if (reply !== {2'b10, 32'h000000f0}) begin
      n_err++; $display("FAIL w8_read got=%h want=%h", reply, {2'b10, 32'h000000f0});
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      drive($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, a, $urandom);
      n_vec++;
      if (reply !== exp_reply || act_ev !== exp_ev || all_val !== exp_vals()) begin
        n_err++; $display("FAIL random i=%0d a=%h reply=%h want=%h ev=%h want=%h", i, a, reply, exp_reply, act_ev, exp_ev);
      end
    end
  endtask

  initial begin
    model_setup();
    test_reset();
    test_constant();
    test_register();
    test_regfile();
    test_nohit();
    test_back_to_back();
    test_async_reset();
    test_width8();
    test_random();
    @(negedge clk) ctrl = '0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
